// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package inst_enc_pkg;

   // Instruction format selector; encodings 6 and 7 are illegal.
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } enc_state_e;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_RANGE = 3'd1;
   localparam logic [2:0] ERR_ALIGN = 3'd2;
   localparam logic [2:0] ERR_FMT   = 3'd3;
   localparam logic [2:0] ERR_FULL  = 3'd4;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // True when bits [31:msb] are all equal, i.e. v is a sign extension
   // of its low msb+1 bits.
   function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb);
      logic [31:0] m;
      m = 32'hFFFF_FFFF << msb;
      return ((v & m) == m) || ((v & m) == 32'h0);
   endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational field packer: scrambles the immediate into the RV32I
// layout for the selected format and reports why a bundle is unusable.
module imm_pack
   import inst_enc_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic [2:0]  err_code
);

   // Pack fields per format; checks run fmt first, then alignment, then range.
   always_comb begin
      inst     = 32'h0;
      err_code = ERR_NONE;
      case (fmt)
         FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            inst = {imm[11:0], rs1, funct3, rd, opcode};
            if (!sext_ok(imm, 11)) err_code = ERR_RANGE;
         end
         FMT_S: begin
            inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            if (!sext_ok(imm, 11)) err_code = ERR_RANGE;
         end
         FMT_B: begin
            inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            if (imm[0])                 err_code = ERR_ALIGN;
            else if (!sext_ok(imm, 12)) err_code = ERR_RANGE;
         end
         FMT_U: begin
            inst = {imm[31:12], rd, opcode};
            if (imm[11:0] != 12'h0) err_code = ERR_RANGE;
         end
         FMT_J: begin
            inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            if (imm[0])                 err_code = ERR_ALIGN;
            else if (!sext_ok(imm, 20)) err_code = ERR_RANGE;
         end
         default: err_code = ERR_FMT;
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Accepts field bundles, encodes them and writes the words sequentially
// into instruction memory, holding each write until the memory acks it.
module inst_encoder
   import inst_enc_pkg::*;
#(
   parameter int ADDR_W    = 14,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   input  logic              last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic [ADDR_W:0]   inst_count,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   enc_state_e  state;
   logic        full;
   logic        last_q;
   logic [31:0] enc_inst;
   logic [2:0]  pack_err;
   logic [2:0]  bundle_err;

   imm_pack u_pack (
      .fmt      (fmt),
      .opcode   (opcode),
      .rd       (rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .funct3   (funct3),
      .funct7   (funct7),
      .imm      (imm),
      .inst     (enc_inst),
      .err_code (pack_err)
   );

   // Once memory has wrapped, every bundle is rejected regardless of content.
   always_comb bundle_err = full ? ERR_FULL : pack_err;

   // Control FSM with registered handshake, write port and status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= BASE;
         mem_wdata  <= 32'h0;
         inst_count <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         full       <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  if (bundle_err != ERR_NONE) begin
                     err <= 1'b1;
                     if (err_code == ERR_NONE) err_code <= bundle_err;
                     if (last) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        in_ready <= 1'b0;
                     end
                  end else begin
                     state     <= S_WRITE;
                     mem_we    <= 1'b1;
                     mem_wdata <= enc_inst;
                     last_q    <= last;
                     in_ready  <= 1'b0;
                  end
               end
            end
            S_WRITE: begin
               if (mem_ack) begin
                  mem_we     <= 1'b0;
                  mem_addr   <= mem_addr + 1'b1;
                  inst_count <= inst_count + 1'b1;
                  if (mem_addr == '1) full <= 1'b1;
                  if (last_q) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= S_IDLE;
                     in_ready <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               in_ready <= 1'b0;
               mem_we   <= 1'b0;
               done     <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder with a 4-word memory (ADDR_W=2).
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  fmt = '0;
   logic [6:0]  opcode = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic [31:0] imm = '0;
   logic        last = 1'b0;
   logic        mem_we;
   logic [1:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [2:0]  inst_count;
   logic        done;
   logic        err;
   logic [2:0]  err_code;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] exp_addr = '0;
   logic [2:0] exp_count = '0;
   int         checks = 0;
   int         errors = 0;

   inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm), .last(last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .inst_count(inst_count), .done(done),
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      exp_addr  = '0;
      exp_count = '0;
      sb.delete();
   endtask

   // Present one bundle for exactly one accepting cycle.
   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im, input logic lst);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (in_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL send_ready: in_ready=%b required 1 within 20 cycles", in_ready);
      end
      fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im; last = lst;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      last = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] data);
      exp_t e;
      e.addr = exp_addr;
      e.data = data;
      sb.push_back(e);
      exp_addr = exp_addr + 1'b1;
   endtask

   // Pop the next expected write, check it, hold ack low for stall cycles, then ack.
   task automatic complete_write(input string name, input int stall);
      exp_t e;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s_sb: scoreboard empty", name);
         return;
      end
      e = sb.pop_front();
      checks++;
      if (mem_we !== 1'b1 || mem_wdata !== e.data || mem_addr !== e.addr) begin
         errors++;
         $display("FAIL %s_write: we=%b data=%h addr=%0d required we=1 data=%h addr=%0d",
                  name, mem_we, mem_wdata, mem_addr, e.data, e.addr);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy: in_ready=%b required 0", name, in_ready);
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         checks++;
         if (mem_we !== 1'b1 || mem_wdata !== e.data || mem_addr !== e.addr) begin
            errors++;
            $display("FAIL %s_stall%0d: we=%b data=%h addr=%0d required we=1 data=%h addr=%0d",
                     name, i, mem_we, mem_wdata, mem_addr, e.data, e.addr);
         end
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      exp_count = exp_count + 1'b1;
      checks++;
      if (mem_we !== 1'b0 || inst_count !== exp_count || mem_addr !== exp_addr) begin
         errors++;
         $display("FAIL %s_ack: we=%b count=%0d addr=%0d required we=0 count=%0d addr=%0d",
                  name, mem_we, inst_count, mem_addr, exp_count, exp_addr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 2'd0 || mem_wdata !== 32'h0 ||
          inst_count !== 3'd0 || done !== 1'b0 || err !== 1'b0 || err_code !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b we=%b addr=%0d wd=%h cnt=%0d done=%b err=%b code=%0d required all 0",
                  in_ready, mem_we, mem_addr, mem_wdata, inst_count, done, err, err_code);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
      end
      exp_addr = '0; exp_count = '0; sb.delete();
   endtask

   // addi, beq, sw, jal fill all four words; jal's ack is stalled.
   task automatic test_encodings();
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
      push_exp(32'h0050_0093);
      complete_write("addi", 0);
      send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0);
      push_exp(32'h0020_8463);
      complete_write("beq", 1);
      send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 1'b0);
      push_exp(32'h0020_A223);
      complete_write("sw", 0);
      send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
      push_exp(32'h0010_00EF);
      complete_write("jal", 5);
   endtask

   // Memory is now full and wrapped; further bundles are rejected.
   task automatic test_full();
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      checks++;
      if (inst_count !== 3'd4 || mem_addr !== 2'd0) begin
         errors++;
         $display("FAIL stray_ack: count=%0d addr=%0d required count=4 addr=0", inst_count, mem_addr);
      end
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
      checks++;
      if (mem_we !== 1'b0 || err !== 1'b1 || err_code !== 3'd4 || inst_count !== 3'd4 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_reject: we=%b err=%b code=%0d cnt=%0d rdy=%b required we=0 err=1 code=4 cnt=4 rdy=1",
                  mem_we, err, err_code, inst_count, in_ready);
      end
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b1);
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || err_code !== 3'd4) begin
         errors++;
         $display("FAIL full_last: done=%b rdy=%b we=%b code=%0d required done=1 rdy=0 we=0 code=4",
                  done, in_ready, mem_we, err_code);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL done_sticky: done=%b rdy=%b required done=1 rdy=0", done, in_ready);
      end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
      checks++;
      if (mem_we !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: mem_we=%b required 1", mem_we);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 2'd0 || inst_count !== 3'd0 || err !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midrst: we=%b addr=%0d cnt=%0d err=%b done=%b required all 0",
                  mem_we, mem_addr, inst_count, err, done);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // First error code is kept; later errors only keep err set.
   task automatic test_errors();
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
      checks++;
      if (err !== 1'b1 || err_code !== 3'd1 || mem_we !== 1'b0 || inst_count !== 3'd0 || mem_addr !== 2'd0) begin
         errors++;
         $display("FAIL err_range: err=%b code=%0d we=%b cnt=%0d addr=%0d required err=1 code=1 we=0 cnt=0 addr=0",
                  err, err_code, mem_we, inst_count, mem_addr);
      end
      send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0);
      checks++;
      if (err_code !== 3'd1 || mem_we !== 1'b0 || inst_count !== 3'd0) begin
         errors++;
         $display("FAIL err_keep: code=%0d we=%b cnt=%0d required code=1 we=0 cnt=0", err_code, mem_we, inst_count);
      end
   endtask

   // Legal bundles at range edges still write normally after an error.
   task automatic test_back_to_back();
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 1'b0);
      push_exp(32'h8000_0093);
      complete_write("addi_min", 0);
      send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094, 1'b0);
      push_exp(32'h7E20_8FE3);
      complete_write("beq_max", 2);
      send(3'd4, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
      push_exp(32'h1234_50B7);
      complete_write("lui_last", 0);
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL last_done: done=%b rdy=%b required done=1 rdy=0", done, in_ready);
      end
   endtask

   task automatic test_codes();
      logic [2:0]  f_tab   [5] = '{3'd3, 3'd7, 3'd4, 3'd3, 3'd2};
      logic [31:0] imm_tab [5] = '{32'd7, 32'd7, 32'h123, 32'd4096, 32'hFFFF_F7FF};
      logic [2:0]  code_tab[5] = '{3'd2, 3'd3, 3'd1, 3'd1, 3'd1};
      for (int i = 0; i < 5; i++) begin
         do_reset();
         send(f_tab[i], 7'b1100011, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, imm_tab[i], 1'b0);
         checks++;
         if (err !== 1'b1 || err_code !== code_tab[i] || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL code_%0d: err=%b code=%0d we=%b required err=1 code=%0d we=0",
                     i, err, err_code, mem_we, code_tab[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_encodings();
      test_full();
      test_reset_mid_write();
      test_errors();
      test_back_to_back();
      test_codes();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
